// File: rtl/pipelined_adder.sv
// WIDTH-bit adder resolving CHUNK bits per stage, with valid/ready flow control on both sides.
// Define PIPELINED_ADDER_OVERFLOW_EN to add the signed-overflow output ovf.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             c_out
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    // Index 0 is the input port side; index k > 0 is the register contents of stage k-1.
    logic [STAGES-1:0] w_up_v;
    logic [STAGES-1:0] w_up_c;
    logic [WIDTH-1:0]  w_up_a   [STAGES];
    logic [WIDTH-1:0]  w_up_b   [STAGES];
    logic [WIDTH-1:0]  w_up_sum [STAGES];
    logic [STAGES:0]   w_rdy;

    assign w_up_v[0]     = in_valid;
    assign w_up_c[0]     = c_in;
    assign w_up_a[0]     = a;
    assign w_up_b[0]     = b;
    assign w_up_sum[0]   = '0;
    assign w_rdy[STAGES] = out_ready;
    assign in_ready      = w_rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        logic             r_v;
        logic             r_carry;
        logic [WIDTH-1:0] r_sum;
        logic [CHUNK:0]   w_add;
        logic [WIDTH-1:0] w_new_sum;

        assign w_rdy[k] = !r_v || w_rdy[k+1];
        assign w_add    = {1'b0, w_up_a[k][k*CHUNK +: CHUNK]}
                        + {1'b0, w_up_b[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, w_up_c[k]};

        always_comb begin
            w_new_sum                      = w_up_sum[k];
            w_new_sum[k*CHUNK +: CHUNK]    = w_add[CHUNK-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v     <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_rdy[k]) begin
                r_v <= w_up_v[k];
                // Bubbles leave the data untouched so outputs only move on real results.
                if (w_up_v[k]) begin
                    r_carry <= w_add[CHUNK];
                    r_sum   <= w_new_sum;
                end
            end
        end

        if (k < LAST) begin : gen_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_rdy[k] && w_up_v[k]) begin
                    r_a <= w_up_a[k];
                    r_b <= w_up_b[k];
                end
            end

            assign w_up_v[k+1]   = r_v;
            assign w_up_c[k+1]   = r_carry;
            assign w_up_a[k+1]   = r_a;
            assign w_up_b[k+1]   = r_b;
            assign w_up_sum[k+1] = r_sum;
        end else begin : gen_out
            // Only the top chunk (and MSBs for overflow) of the operands matter here.
            logic w_unused_ab;
            assign w_unused_ab = ^{w_up_a[k], w_up_b[k]};

            assign out_valid = r_v;
            assign sum       = r_sum;
            assign c_out     = r_carry;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
            logic r_ovf;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_rdy[k] && w_up_v[k]) begin
                    r_ovf <= (w_up_a[k][WIDTH-1] == w_up_b[k][WIDTH-1])
                          && (w_new_sum[WIDTH-1] != w_up_a[k][WIDTH-1]);
                end
            end

            assign ovf = r_ovf;
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised, self-checking bench for pipelined_adder against an arithmetic reference model.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             c_in      = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic             ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected {c_out, sum} for every accepted but not yet delivered transaction.
    logic [WIDTH:0] q_exp[$];

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model_add(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y,
                                                 logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s >= (2 ** (WIDTH - 1))) || (s < -(2 ** (WIDTH - 1)));
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if ({c_out, sum} !== '0) begin
            n_fail++; $display("FAIL reset_sum: got %h want 0", {c_out, sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_carry_chain();
        logic [WIDTH:0] e;
        @(negedge clk);
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; out_ready = 1'b1;
        e = model_add(a, b, c_in);
        for (int i = 0; i < int'(STAGES); i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            n_cmp++;
            if (out_valid !== (i == int'(STAGES) - 1)) begin
                n_fail++; $display("FAIL carry_latency: cycle %0d got %b", i + 1, out_valid);
            end
        end
        n_cmp++;
        if ({c_out, sum} !== e) begin
            n_fail++; $display("FAIL carry_chain: got %h want %h", {c_out, sum}, e);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL carry_drain: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        logic             tc [3];
        logic [WIDTH:0]   e;
        ta[0] = 16'h1234; tb[0] = 16'h4321; tc[0] = 1'b1;
        ta[1] = 16'h0F0F; tb[1] = 16'h00F1; tc[1] = 1'b0;
        ta[2] = 16'h8000; tb[2] = 16'h8000; tc[2] = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 3);
            if (cyc < 3) begin
                a = ta[cyc]; b = tb[cyc]; c_in = tc[cyc];
            end
            #1;
            if (cyc == 3) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_early: got out_valid %b want 0", out_valid);
                end
            end
            if (cyc >= 4) begin
                e = model_add(ta[cyc-4], tb[cyc-4], tc[cyc-4]);
                n_cmp++;
                if (out_valid !== 1'b1 || {c_out, sum} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got v=%b %h want v=1 %h",
                             cyc - 4, out_valid, {c_out, sum}, e);
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_extra: got out_valid %b want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        int             sent = 0;
        int             got  = 0;
        logic [WIDTH:0] e;
        q_exp.delete();
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 6);
            in_valid  = (sent < 8);
            a = WIDTH'(sent); b = 16'h0100; c_in = 1'b0;
            #1;
            if (cyc == 4 || cyc == 5) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 4) begin
                    n_fail++; $display("FAIL stall_full: in_ready %b after %0d accepted, want 0 after 4",
                                       in_ready, sent);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || {c_out, sum} !== q_exp[0]) begin
                    n_fail++; $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                                       out_valid, {c_out, sum}, q_exp[0]);
                end
            end
            n_cmp++;
            if (in_ready !== (q_exp.size() < int'(STAGES) || out_ready)) begin
                n_fail++; $display("FAIL stall_in_ready: got %b with %0d in flight",
                                   in_ready, q_exp.size());
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_fail++; $display("FAIL stall_spurious: got %h want nothing", {c_out, sum});
                end else begin
                    e = q_exp.pop_front();
                    if ({c_out, sum} !== e) begin
                        n_fail++; $display("FAIL stall_order: got %h want %h", {c_out, sum}, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(model_add(a, b, c_in));
                sent++;
            end
        end
        n_cmp++;
        if (got != 8) begin
            n_fail++; $display("FAIL stall_count: got %0d results want 8", got);
        end
        in_valid = 1'b0;
        repeat (int'(STAGES)) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL stall_dup: got out_valid %b want 0", out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic           p_stall = 1'b0;
        logic [WIDTH:0] p_out   = '0;
        logic [WIDTH:0] e;
        q_exp.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            in_valid  = (cyc % 2 == 0);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            c_in      = 1'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            n_cmp++;
            if (in_ready !== (q_exp.size() < int'(STAGES) || out_ready)) begin
                n_fail++; $display("FAIL rand_in_ready: got %b with %0d in flight or=%b",
                                   in_ready, q_exp.size(), out_ready);
            end
            if (q_exp.size() == 0) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rand_empty: got out_valid %b want 0", out_valid);
                end
            end
            if (p_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {c_out, sum} !== p_out) begin
                    n_fail++; $display("FAIL rand_stable: got v=%b %h want v=1 %h",
                                       out_valid, {c_out, sum}, p_out);
                end
            end
            p_stall = out_valid && !out_ready;
            p_out   = {c_out, sum};
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: got %h want nothing", {c_out, sum});
                end else begin
                    e = q_exp.pop_front();
                    if ({c_out, sum} !== e) begin
                        n_fail++; $display("FAIL rand_result: got %h want %h", {c_out, sum}, e);
                    end
                end
            end
            if (in_valid && in_ready) q_exp.push_back(model_add(a, b, c_in));
        end
        for (int cyc = 0; cyc < 20 && q_exp.size() > 0; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                e = q_exp.pop_front();
                n_cmp++;
                if ({c_out, sum} !== e) begin
                    n_fail++; $display("FAIL rand_drain: got %h want %h", {c_out, sum}, e);
                end
            end
        end
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_fail++; $display("FAIL rand_lost: %0d results never arrived, want 0", q_exp.size());
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(STAGES) + 2; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_stale: got v=%b rdy=%b want v=0 rdy=1",
                                   out_valid, in_ready);
            end
            @(negedge clk);
        end
    endtask

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [WIDTH-1:0] ta [2];
        logic [WIDTH-1:0] tb [2];
        logic [WIDTH:0]   e;
        logic             eo;
        ta[0] = 16'h7FFF; tb[0] = 16'h0001;
        ta[1] = 16'hFFFF; tb[1] = 16'h0001;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            in_valid = (cyc < 2);
            if (cyc < 2) begin
                a = ta[cyc]; b = tb[cyc]; c_in = 1'b0;
            end
            #1;
            if (cyc >= 4) begin
                e  = model_add(ta[cyc-4], tb[cyc-4], 1'b0);
                eo = model_ovf(ta[cyc-4], tb[cyc-4], 1'b0);
                n_cmp++;
                if (out_valid !== 1'b1 || {c_out, sum} !== e || ovf !== eo) begin
                    n_fail++; $display("FAIL ovf%0d: got v=%b %h ovf=%b want v=1 %h ovf=%b",
                                       cyc - 4, out_valid, {c_out, sum}, ovf, e, eo);
                end
            end
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the 4-bit ripple adder.
- Adds two WIDTH-bit operands plus carry-in. The operands are split into STAGES equal chunks, and one chunk is resolved per pipeline stage.
- Valid/ready handshakes are used on both input and output, with per-stage bubble collapsing.
- Sits in the datapath wherever a wide add must close timing at full clock rate, at a throughput of one result per cycle.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline stages, which is also the latency in cycles. Range 1..WIDTH.
- CHUNK (localparam), WIDTH/STAGES, bits resolved per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- c_in  input  1  carry-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH
- c_out  output  1  carry out of bit WIDTH-1

Behaviour:
- One clock, asynchronous active-low reset (rst_n); all state clears on reset.
- Reset values:
  - all stage valid bits 0, so out_valid = 0.
  - all stage data, sum and c_out are 0.
  - in_ready = 1 once rst_n is high (all stages empty).
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready at a rising edge.
- Stage k (0..STAGES-1):
  - holds valid v[k], the partial sum of chunks 0..k, a carry, and the unprocessed upper chunks of a and b.
  - stage k computes chunk k = a_chunk + b_chunk + carry from stage k-1 (c_in for k = 0).
  - upper chunks pass through unchanged.
- Stage-ready chain:
  - rdy[k] = !v[k] || rdy[k+1], with rdy[STAGES] = out_ready.
  - in_ready = rdy[0], combinational from out_ready.
  - A stage loads when rdy[k] is high. It loads a bubble (v = 0) if the upstream stage is not valid.
- Latency: exactly STAGES cycles from input transfer to out_valid, when never stalled.
- Throughput: one transfer per cycle while out_ready is held high.
- Output stability: while out_valid && !out_ready, sum, c_out and out_valid hold stable; upstream bubbles still collapse.
- Ordering: results leave strictly in acceptance order; no drops, no duplicates.
- Pipeline full: all v[k] = 1 and out_ready = 0 gives in_ready = 0; in_valid is ignored.
- Simultaneous output and input transfer while full is allowed (same edge); occupancy is unchanged.
- Wrap-around: the sum is truncated to WIDTH bits and the overflow carry appears on c_out.
- STAGES = 1: a single registered adder with latency 1.
- Reset mid-operation: all in-flight results are discarded immediately (asynchronously); out_valid = 0 while rst_n is low.
- Input operands need only be valid in the transfer cycle; the block captures them.

Optional Feature:
- Macro: PIPELINED_ADDER_OVERFLOW_EN.
- Defined:
  - adds output port ovf (1 bit), signed two's-complement overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - ovf is computed in the final stage and is aligned with sum and c_out.
  - ovf resets to 0 and is held under stall.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1. Apply a=0xFFFF, b=0x0001, c_in=0. Required: out_valid exactly 4 cycles later with sum=0x0000, c_out=1 (carry crosses all chunk boundaries).
- Apply a=0x1234, b=0x4321, c_in=1, then immediately 0x0F0F+0x00F1+0 and 0x8000+0x8000+0 on consecutive cycles. Required: results 0x5556/c_out=0, 0x1000/c_out=0, 0x0000/c_out=1 on three consecutive cycles starting at cycle 4.
- Stream 8 incrementing transactions (a=i, b=0x0100, c_in=0) with out_ready=0 for 6 cycles. Required: in_ready drops after 4 accepted; sum holds at 0x0100 during the stall. After release, all 8 sums 0x0100..0x0107 appear in order, none lost or duplicated.
- Pulse in_valid every other cycle with out_ready toggled pseudo-randomly, then compare against a + b + c_in. Required: all results match, and bubbles collapse (in_ready=1 whenever any stage is empty).
- Assert rst_n=0 mid-stream with 3 results in flight. Required: out_valid=0 immediately; after release, no stale results emerge and in_ready=1.
- With PIPELINED_ADDER_OVERFLOW_EN: 0x7FFF+0x0001 gives sum=0x8000, c_out=0, ovf=1; 0xFFFF+0x0001 gives ovf=0, c_out=1.
